// File: rtl/crc_frame_buffer.sv
// crc_frame_buffer
//   Byte-stream buffer between a UART and the inter-FPGA link. Bytes are
//   absorbed in a first-word-fall-through FIFO; a running CRC-8 is computed
//   over each frame as its bytes leave the FIFO. A frame counter and the
//   CRC of the last completed frame are kept for the displays.
//
//   Build option: define CRC_FRAME_APPEND_EN to append the frame CRC as a
//   trailer byte after every frame. In that build out_last marks the trailer.
//   Without the macro the stream passes unmodified and out_last marks the
//   final payload byte.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   POLY      CRC-8 generator polynomial, MSB-first, no reflection/final XOR
//   CRC_INIT  CRC register value at the start of every frame
//   CNT_W     frame counter width
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous flush of FIFO, FSM and CRC register
//   in_data/last/valid     upstream byte, end-of-frame marker, valid
//   in_ready               upstream ready (= FIFO not full)
//   out_data/last/valid    downstream byte, end-of-frame marker, valid
//   out_ready              downstream ready
//   crc_out, crc_valid     CRC of last completed frame, one-cycle pulse
//   frame_count            completed frames (wraps)
//   level                  FIFO occupancy, 0..DEPTH
module crc_frame_buffer #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] POLY     = 8'h07,
  parameter logic [7:0] CRC_INIT = 8'h00,
  parameter int         CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               crc_out,
  output logic                     crc_valid,
  output logic [CNT_W-1:0]         frame_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

`ifdef CRC_FRAME_APPEND_EN
  typedef enum logic {S_DATA, S_CRC} state_t;
`else
  typedef enum logic {S_DATA} state_t;
`endif

  // Serial MSB-first CRC-8 step over one byte, unrolled into one cycle.
  function automatic logic [7:0] crc8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? POLY : 8'h00);
    end
    return c;
  endfunction

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [8:0]  head;
  logic        full, empty, push, pop;
  logic [7:0]  crc_q, crc_d, crc_next, done_crc;
  logic        complete;
  state_t      state_q, state_d;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign in_ready = !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign crc_next = crc8(crc_q, head[7:0]);
  // A clear in the same cycle swallows the incoming byte.
  assign push     = in_valid && in_ready && !clear;

  // FIFO storage: data only, no reset needed since out_data is gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
    end
  end

  // Output / next-state decode.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    done_crc  = crc_next;
    complete  = 1'b0;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      S_DATA: begin
        out_valid = !empty;
        out_data  = empty ? 8'h00 : head[7:0];
`ifdef CRC_FRAME_APPEND_EN
        out_last  = 1'b0;
`else
        out_last  = !empty && head[8];
`endif
        if (out_valid && out_ready) begin
          pop   = 1'b1;
          crc_d = crc_next;
          if (head[8]) begin
`ifdef CRC_FRAME_APPEND_EN
            state_d = S_CRC;
`else
            complete = 1'b1;
            crc_d    = CRC_INIT;
`endif
          end
        end
      end
`ifdef CRC_FRAME_APPEND_EN
      S_CRC: begin
        out_valid = 1'b1;
        out_data  = crc_q;
        out_last  = 1'b1;
        done_crc  = crc_q;
        if (out_ready) begin
          complete = 1'b1;
          crc_d    = CRC_INIT;
          state_d  = S_DATA;
        end
      end
`endif
      default: ;
    endcase
    // Flush wins over any transfer; a pending trailer is dropped uncounted.
    if (clear) begin
      state_d  = S_DATA;
      crc_d    = CRC_INIT;
      pop      = 1'b0;
      complete = 1'b0;
    end
  end

  // State, pointers and frame statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state_q     <= S_DATA;
      crc_q       <= CRC_INIT;
      crc_out     <= 8'h00;
      crc_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      crc_valid <= complete;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (complete) begin
        crc_out     <= done_crc;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
